// File: rtl/ch_unit_if.sv
// Port-B word bus between the AXI BRAM controller and the channel pattern memory.
interface ch_unit_if #(
    parameter int N_ADDR_BITS = 20
) ();
    logic                   enb;
    logic                   web;
    logic [N_ADDR_BITS-6:0] addrb;
    logic [31:0]            dinb;
    logic [31:0]            doutb;

    modport master (output enb, web, addrb, dinb, input doutb);
    modport slave  (input enb, web, addrb, dinb, output doutb);
endinterface

// File: rtl/ch_unit.sv
// Single-channel pattern playback: 1-bit pattern memory streamed onto ch_out between
// start/stop pointers, with a 32-bit port B for bulk load and readback.
module ch_unit #(
    parameter int N_ADDR_BITS = 20,
    parameter int DATA_WIDTH  = 1,
    parameter int MEM_DEPTH   = 1048576
) (
    input  logic                   s_axi_clk,
    input  logic                   s_axi_reset,
    input  logic                   i_playback_ce,
    input  logic                   i_gpio_mode,
    input  logic [N_ADDR_BITS-1:0] i_gpio_set_ram_addr,
    input  logic                   i_gpio_write_addr,
    input  logic [N_ADDR_BITS-1:0] i_gpio_stop_addr,
    input  logic                   i_gpio_write_stop_addr,
    input  logic                   i_gpio_loop_playback,
    input  logic                   i_gpio_playback_en,
    input  logic                   i_gpio_write_ram,
    input  logic [DATA_WIDTH-1:0]  i_gpio_din,
    output logic                   ch_out,
    output logic [N_ADDR_BITS-1:0] o_gpio_addr_readback,
    output logic                   o_gpio_playback_done,
    ch_unit_if.slave               bram
);
    localparam int N_WORDS = MEM_DEPTH / 32;
    localparam logic [N_ADDR_BITS-1:0] PTR_ONE = 1;

    logic [31:0] mem [N_WORDS];

    logic [N_ADDR_BITS-1:0] ptr_q, ptr_d;
    logic [N_ADDR_BITS-1:0] start_q, start_d;
    logic [N_ADDR_BITS-1:0] stop_q, stop_d;
    logic                   ch_out_q, ch_out_d;
    logic                   done_q, done_d;
    logic [31:0]            doutb_q, doutb_d;
    logic                   wa_prev_q, wa_prev_d;
    logic                   ws_prev_q, ws_prev_d;
    logic                   wr_prev_q, wr_prev_d;
    logic                   en_prev_q, en_prev_d;

    logic        wa_rise, ws_rise, wr_rise, en_fall;
    logic        bit_we, step;
    logic [31:0] play_word;
    logic        play_bit;

    always_comb begin
        wa_rise   = i_gpio_write_addr & ~wa_prev_q;
        ws_rise   = i_gpio_write_stop_addr & ~ws_prev_q;
        wr_rise   = i_gpio_write_ram & ~wr_prev_q;
        en_fall   = en_prev_q & ~i_gpio_playback_en;
        bit_we    = i_gpio_mode & wr_rise;
        step      = ~i_gpio_mode & i_gpio_playback_en & ~done_q & i_playback_ce;
        play_word = mem[ptr_q[N_ADDR_BITS-1:5]];
        play_bit  = play_word[ptr_q[4:0]];

        ptr_d     = ptr_q;
        start_d   = start_q;
        stop_d    = stop_q;
        ch_out_d  = ch_out_q;
        done_d    = done_q;
        doutb_d   = bram.enb ? mem[bram.addrb] : doutb_q;
        wa_prev_d = i_gpio_write_addr;
        ws_prev_d = i_gpio_write_stop_addr;
        wr_prev_d = i_gpio_write_ram;
        en_prev_d = i_gpio_playback_en;

        if (i_gpio_mode) begin
            ch_out_d = 1'b0;
            if (bit_we) ptr_d = ptr_q + PTR_ONE;
        end else if (!i_gpio_playback_en) begin
            ch_out_d = 1'b0;
        end else if (step) begin
            ch_out_d = play_bit;
            if (ptr_q == stop_q) begin
                if (i_gpio_loop_playback) ptr_d = start_q;
                else                      done_d = 1'b1;
            end else begin
                ptr_d = ptr_q + PTR_ONE;
            end
        end

        if (en_fall) done_d = 1'b0;
        if (ws_rise) stop_d = i_gpio_stop_addr;
        // Pointer load overrides any step or bit-load advance in the same cycle.
        if (wa_rise) begin
            start_d = i_gpio_set_ram_addr;
            ptr_d   = i_gpio_set_ram_addr;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge s_axi_clk or posedge s_axi_reset) begin
        if (s_axi_reset) begin
            ptr_q     <= '0;
            start_q   <= '0;
            stop_q    <= '0;
            ch_out_q  <= 1'b0;
            done_q    <= 1'b0;
            doutb_q   <= '0;
            wa_prev_q <= 1'b0;
            ws_prev_q <= 1'b0;
            wr_prev_q <= 1'b0;
            en_prev_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            ch_out_q  <= ch_out_d;
            done_q    <= done_d;
            doutb_q   <= doutb_d;
            wa_prev_q <= wa_prev_d;
            ws_prev_q <= ws_prev_d;
            wr_prev_q <= wr_prev_d;
            en_prev_q <= en_prev_d;
        end
    end

    // Port B is written last so it owns the whole word on a same-word collision.
    always_ff @(posedge s_axi_clk) begin
        if (bit_we) mem[ptr_q[N_ADDR_BITS-1:5]][ptr_q[4:0]] <= i_gpio_din[0];
        if (bram.enb && bram.web) mem[bram.addrb] <= bram.dinb;
    end

    assign ch_out               = ch_out_q;
    assign o_gpio_addr_readback = ptr_q;
    assign o_gpio_playback_done = done_q;
    assign bram.doutb           = doutb_q;
endmodule

// File: tb/tb_ch_unit.sv
// Scoreboard bench for ch_unit: port-B fill/readback, playback mapping, loop, wrap,
// bit-load, collisions and asynchronous reset.
module tb_ch_unit;
    localparam int NA = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce, mode, wa, ws, lp, en, wr;
    logic [NA-1:0] set_addr, stop_addr;
    logic [0:0]    din;
    logic          ch_out, done;
    logic [NA-1:0] rb;

    always #5 clk = ~clk;

    ch_unit_if #(.N_ADDR_BITS(NA)) bus ();

    ch_unit #(.N_ADDR_BITS(NA), .DATA_WIDTH(1), .MEM_DEPTH(1 << NA)) dut (
        .s_axi_clk              (clk),
        .s_axi_reset            (rst),
        .i_playback_ce          (ce),
        .i_gpio_mode            (mode),
        .i_gpio_set_ram_addr    (set_addr),
        .i_gpio_write_addr      (wa),
        .i_gpio_stop_addr       (stop_addr),
        .i_gpio_write_stop_addr (ws),
        .i_gpio_loop_playback   (lp),
        .i_gpio_playback_en     (en),
        .i_gpio_write_ram       (wr),
        .i_gpio_din             (din),
        .ch_out                 (ch_out),
        .o_gpio_addr_readback   (rb),
        .o_gpio_playback_done   (done),
        .bram                   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboards: playback entries are {ch_out, done, pointer}
    logic [NA+1:0] play_q[$];
    logic [31:0]   rd_q[$];
    logic [31:0]   mdl[int];

    logic [NA-1:0] m_ptr, m_start, m_stop;
    logic          m_done, m_ch;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pb_write(input int a, input logic [31:0] d);
        bus.enb   = 1'b1;
        bus.web   = 1'b1;
        bus.addrb = a[NA-6:0];
        bus.dinb  = d;
        tick();
        bus.enb   = 1'b0;
        bus.web   = 1'b0;
        mdl[a]    = d;
    endtask

    task automatic pb_read_issue(input int a);
        bus.enb   = 1'b1;
        bus.web   = 1'b0;
        bus.addrb = a[NA-6:0];
        rd_q.push_back(mdl[a]);
        tick();
        bus.enb   = 1'b0;
    endtask

    // Advances the reference model by one ce step, then strobes ce for one cycle.
    task automatic step_issue();
        logic [31:0] w;
        if (!m_done) begin
            w    = mdl[int'(m_ptr[NA-1:5])];
            m_ch = w[m_ptr[4:0]];
            if (m_ptr == m_stop) begin
                if (lp) m_ptr = m_start;
                else    m_done = 1'b1;
            end else begin
                m_ptr = m_ptr + 1'b1;
            end
        end
        play_q.push_back({m_ch, m_done, m_ptr});
        ce = 1'b1;
        tick();
        ce = 1'b0;
    endtask

    task automatic load_ptr(input logic [NA-1:0] a);
        set_addr = a;
        wa = 1'b1;
        tick();
        wa = 1'b0;
        tick();
        m_ptr   = a;
        m_start = a;
        m_done  = 1'b0;
    endtask

    task automatic set_stop(input logic [NA-1:0] a);
        stop_addr = a;
        ws = 1'b1;
        tick();
        ws = 1'b0;
        tick();
        m_stop = a;
    endtask

    task automatic setup(input logic [NA-1:0] s, input logic [NA-1:0] e, input logic l);
        en = 1'b0;
        tick();
        m_ch   = 1'b0;
        m_done = 1'b0;
        lp = l;
        set_stop(e);
        load_ptr(s);
        en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({ch_out, done, rb} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got ch=%b done=%b ptr=%h, expected all zero", ch_out, done, rb);
        end
        n_checks++;
        if (bus.doutb !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_doutb: got %h expected 00000000", bus.doutb);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_portb_fill();
        logic [31:0] exp;
        for (int i = 0; i < 32; i++) pb_write(i, 32'(i) * 32'h9E37_79B9);
        for (int i = 0; i < 32; i++) begin
            pb_read_issue(i);
            exp = rd_q.pop_front();
            n_checks++;
            if (bus.doutb !== exp) begin
                n_fail++;
                $display("FAIL portb_read[%0d]: got %h expected %h", i, bus.doutb, exp);
            end
        end
        tick();
        n_checks++;
        if (bus.doutb !== 32'd31 * 32'h9E37_79B9) begin
            n_fail++;
            $display("FAIL portb_hold: got %h expected %h", bus.doutb, 32'd31 * 32'h9E37_79B9);
        end
    endtask

    task automatic test_bit_mapping();
        logic [NA+1:0] exp;
        pb_write(0, 32'h0000_0005);
        setup('0, 20'd3, 1'b0);
        for (int s = 0; s < 5; s++) begin
            step_issue();
            exp = play_q.pop_front();
            n_checks++;
            if ({ch_out, done, rb} !== exp) begin
                n_fail++;
                $display("FAIL map_step[%0d]: got %h expected %h", s, {ch_out, done, rb}, exp);
            end
            repeat (9) tick();
            n_checks++;
            if ({ch_out, done, rb} !== exp) begin
                n_fail++;
                $display("FAIL map_hold[%0d]: got %h expected %h", s, {ch_out, done, rb}, exp);
            end
        end
        n_checks++;
        if (done !== 1'b1 || rb !== 20'd3) begin
            n_fail++;
            $display("FAIL map_done: got done=%b ptr=%h expected done=1 ptr=00003", done, rb);
        end
        en = 1'b0;
        tick();
        n_checks++;
        if ({ch_out, done, rb} !== {1'b0, 1'b0, 20'd3}) begin
            n_fail++;
            $display("FAIL en_fall: got ch=%b done=%b ptr=%h expected ch=0 done=0 ptr=00003", ch_out, done, rb);
        end
    endtask

    task automatic test_loop();
        logic [NA+1:0] exp;
        setup(20'd1, 20'd2, 1'b1);
        for (int s = 0; s < 6; s++) begin
            step_issue();
            exp = play_q.pop_front();
            n_checks++;
            if ({ch_out, done, rb} !== exp) begin
                n_fail++;
                $display("FAIL loop_step[%0d]: got %h expected %h", s, {ch_out, done, rb}, exp);
            end
            repeat (9) tick();
        end
    endtask

    task automatic test_wrap();
        logic [NA+1:0] exp;
        pb_write(32'h7FFF, 32'h8000_0000);
        setup(20'hFFFFE, 20'h00001, 1'b0);
        for (int s = 0; s < 5; s++) begin
            step_issue();
            exp = play_q.pop_front();
            n_checks++;
            if ({ch_out, done, rb} !== exp) begin
                n_fail++;
                $display("FAIL wrap_step[%0d]: got %h expected %h", s, {ch_out, done, rb}, exp);
            end
            repeat (9) tick();
        end
    endtask

    task automatic test_bitload();
        logic [31:0] exp;
        logic [2:0]  bits = 3'b011;
        logic [31:0] w;
        pb_write(2, 32'h0);
        en = 1'b0;
        mode = 1'b1;
        load_ptr(20'd64);
        for (int i = 0; i < 3; i++) begin
            din = bits[i];
            wr = 1'b1;
            tick();
            wr = 1'b0;
            tick();
            w = mdl[2];
            w[m_ptr[4:0]] = bits[i];
            mdl[2] = w;
            m_ptr = m_ptr + 1'b1;
        end
        n_checks++;
        if (rb !== 20'd67 || ch_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bitload_ptr: got ptr=%h ch=%b expected ptr=00043 ch=0", rb, ch_out);
        end
        pb_read_issue(2);
        exp = rd_q.pop_front();
        n_checks++;
        if (bus.doutb !== exp || bus.doutb !== 32'h0000_0003) begin
            n_fail++;
            $display("FAIL bitload_word: got %h expected %h", bus.doutb, exp);
        end
        // Port-A bit write and port-B word write to word 2 in the same cycle
        din = 1'b1;
        wr = 1'b1;
        bus.enb = 1'b1;
        bus.web = 1'b1;
        bus.addrb = 15'd2;
        bus.dinb = 32'h1234_5670;
        tick();
        wr = 1'b0;
        bus.enb = 1'b0;
        bus.web = 1'b0;
        mdl[2] = 32'h1234_5670;
        tick();
        pb_read_issue(2);
        exp = rd_q.pop_front();
        n_checks++;
        if (bus.doutb !== exp) begin
            n_fail++;
            $display("FAIL collide_word: got %h expected %h", bus.doutb, exp);
        end
        mode = 1'b0;
    endtask

    task automatic test_collide_playback();
        logic [NA+1:0] exp;
        pb_write(0, 32'h0000_0005);
        setup('0, 20'd5, 1'b0);
        bus.enb = 1'b1;
        bus.web = 1'b1;
        bus.addrb = '0;
        bus.dinb = 32'h0;
        step_issue();
        bus.enb = 1'b0;
        bus.web = 1'b0;
        mdl[0] = 32'h0;
        exp = play_q.pop_front();
        n_checks++;
        if ({ch_out, done, rb} !== exp) begin
            n_fail++;
            $display("FAIL collide_play: got %h expected %h", {ch_out, done, rb}, exp);
        end
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            step_issue();
            exp = play_q.pop_front();
            n_checks++;
            if ({ch_out, done, rb} !== exp) begin
                n_fail++;
                $display("FAIL collide_after[%0d]: got %h expected %h", s, {ch_out, done, rb}, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [NA+1:0] exp;
        logic [31:0]   wexp;
        pb_write(0, 32'h0000_0004);
        setup(20'd1, 20'd2, 1'b1);
        for (int s = 0; s < 2; s++) begin
            step_issue();
            exp = play_q.pop_front();
            n_checks++;
            if ({ch_out, done, rb} !== exp) begin
                n_fail++;
                $display("FAIL rstmid_step[%0d]: got %h expected %h", s, {ch_out, done, rb}, exp);
            end
            repeat (2) tick();
        end
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ch_out, done, rb} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: got ch=%b done=%b ptr=%h expected all zero", ch_out, done, rb);
        end
        en = 1'b0;
        lp = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 6; i += 5) begin
            pb_read_issue(i);
            wexp = rd_q.pop_front();
            n_checks++;
            if (bus.doutb !== wexp) begin
                n_fail++;
                $display("FAIL rstmid_mem[%0d]: got %h expected %h", i, bus.doutb, wexp);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ce = 1'b0; mode = 1'b0; wa = 1'b0; ws = 1'b0; lp = 1'b0; en = 1'b0; wr = 1'b0;
        set_addr = '0; stop_addr = '0; din = '0;
        bus.enb = 1'b0; bus.web = 1'b0; bus.addrb = '0; bus.dinb = '0;
        m_ptr = '0; m_start = '0; m_stop = '0; m_done = 1'b0; m_ch = 1'b0;
        test_reset();
        test_portb_fill();
        test_bit_mapping();
        test_loop();
        test_wrap();
        test_bitload();
        test_collide_playback();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ch_unit.md
Name: ch_unit

Overview:
- Single-channel pattern playback unit: a 1-bit-wide, MEM_DEPTH-deep pattern memory streamed bit-serially onto ch_out between programmable start and stop addresses, with optional looping.
- The memory is also exposed as a 32-bit-wide port B for bulk load/readback from the AXI BRAM controller.
- GPIO-style control inputs come from the channel's register block.
- Everything runs on s_axi_clk; playback rate is set by a clock-enable strobe.

Parameters:
- N_ADDR_BITS, 20, width of bit-address (port A) and pointer registers.
- DATA_WIDTH, 1, port-A data width; only 1 is supported.
- MEM_DEPTH, 1048576, memory depth in bits; must equal 2**N_ADDR_BITS.

Ports:
- s_axi_clk  in  1  sole clock.
- s_axi_reset  in  1  asynchronous, active-high reset.
- i_playback_ce  in  1  playback step strobe, one s_axi_clk cycle wide per output bit.
- i_gpio_mode  in  1  0 = playback, 1 = bit-load.
- i_gpio_set_ram_addr  in  N_ADDR_BITS  start address.
- i_gpio_write_addr  in  1  rising edge loads pointer from start address.
- i_gpio_stop_addr  in  N_ADDR_BITS  stop address.
- i_gpio_write_stop_addr  in  1  rising edge latches stop address.
- i_gpio_loop_playback  in  1  1 = restart at start address after stop address.
- i_gpio_playback_en  in  1  level enable for playback.
- i_gpio_write_ram  in  1  rising edge writes i_gpio_din at pointer (mode 1).
- i_gpio_din  in  DATA_WIDTH  bit to write.
- ch_out  out  1  serial channel output.
- o_gpio_addr_readback  out  N_ADDR_BITS  current pointer.
- o_gpio_playback_done  out  1  playback reached stop address without loop.
- enb  in  1  port-B enable.
- web  in  1  port-B write enable.
- addrb  in  N_ADDR_BITS-5  word address.
- dinb  in  32  write data.
- doutb  out  32  read data.

Behaviour:
- Storage: MEM_DEPTH/32 words of 32 bits. Bit address a maps to word a[N-1:5], bit a[4:0] (LSB = lowest bit address). Contents are not reset.
- Reset values:
  - pointer, start, stop, ch_out, doutb, o_gpio_playback_done = 0.
  - Edge-detect registers = 0.
- Control edges: write_addr, write_stop_addr and write_ram are rising-edge detected (registered previous value); holding a strobe high acts once.
- Pointer load:
  - A write_addr edge sets pointer <= i_gpio_set_ram_addr and clears done.
  - A write_stop_addr edge latches stop.
  - Both edges in the same cycle are legal.
- Bit-load (mode=1): a write_ram edge writes din to mem[pointer], then pointer <= pointer+1 on the next cycle, wrapping from MEM_DEPTH-1 to 0. Playback is inactive and ch_out = 0.
- Playback (mode=0, playback_en=1, done=0), on each cycle with i_playback_ce=1:
  - ch_out <= mem[pointer] (registered, 1-cycle latency).
  - If pointer==stop: pointer <= start when loop=1; otherwise done <= 1 and pointer holds.
  - Else pointer <= pointer+1, wrapping at MEM_DEPTH-1.
- Playback idle states:
  - Pointer and ch_out hold when ce=0.
  - When playback_en=0, ch_out <= 0 and pointer holds.
  - Done clears on a playback_en falling edge or a write_addr edge.
- Done is sticky: while done=1, ch_out holds the last bit until done clears.
- Port B:
  - enb=1, web=1: word write.
  - enb=1: doutb <= old word (read-first), 1-cycle latency.
  - enb=0: doutb holds.
- Collision: a port-B write and a port-A write to the same word in one cycle → port B wins the whole word. A port-B write to the bit under playback in the same cycle → ch_out gets the old value.
- o_gpio_addr_readback = pointer, combinational from the register.
- Reset mid-playback aborts immediately to reset values; memory is retained.

Test Plan:
- Port-B fill/readback: write word i = i*0x9E3779B9 for i=0..31 → read each back; doutb matches one cycle after the enb read.
- Bit mapping: write word 0 = 0x0000_0005, start=0, stop=3, loop=0, enable with ce every 10 clocks → ch_out sequence 1,0,1,0; done=1 after 4th step; readback holds 3.
- Loop: same data, loop=1, start=1, stop=2 → ch_out 0,1,0,1,…; done stays 0; pointer cycles 1,2,1,2.
- Wrap: start=0xFFFFE, stop=0x00001, loop=0 → pointer goes 0xFFFFE, 0xFFFFF, 0x00000, 0x00001 then done.
- Bit-load: mode=1, load pointer 64, three write_ram pulses with din 1,1,0 → port-B read of word 2 = 0x0000_0003; readback = 67.
- Reset mid-playback: assert s_axi_reset during looping playback → ch_out, done, readback = 0 asynchronously; previously written memory is still readable via port B.
